// File: rtl/byte_entry_display_pkg.sv
// Shared widths, FSM state type and active-low 7-segment codes (bit0=a .. bit6=g).
package byte_entry_display_pkg;
  localparam int DATA_W     = 8;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;
  localparam int NUM_DIGITS = 4;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  // All segments off; kept for blanking leading digits later.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/byte_entry_display_hex_to_7seg.sv
// One hex nibble to active-low 7-segment pattern, purely combinational.
module hex_to_7seg
  import byte_entry_display_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg
);
  // Lookup of the hex glyph; every nibble value is covered.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/byte_entry_display.sv
// Captures a byte per enter press and shows the last two bytes as four hex digits.
// Control FSM and datapath talk only through w_inputdata_ready / w_loaddata.
module byte_entry_display
  import byte_entry_display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] inputdata,
  output logic [SEG_W-1:0]  disp3,
  output logic [SEG_W-1:0]  disp2,
  output logic [SEG_W-1:0]  disp1,
  output logic [SEG_W-1:0]  disp0
);
  logic                                r_s1, r_s2, r_s3;
  logic                                w_inputdata_ready;
  logic                                w_loaddata;
  state_t                              r_state, w_next_state;
  logic [DATA_W-1:0]                   r_cur, r_prev;
  logic [NUM_DIGITS-1:0][NIB_W-1:0]    w_nib;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    w_seg;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= enter;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // One pulse per synchronized rising edge, however long enter is held.
  assign w_inputdata_ready = r_s2 & ~r_s3;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state; a ready pulse arriving in LOAD is dropped, not queued.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_inputdata_ready) w_next_state = LOAD;
      LOAD: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output: load command for exactly the one cycle spent in LOAD.
  always_comb begin
    w_loaddata = 1'b0;
    if (r_state == LOAD) w_loaddata = 1'b1;
  end

  // Byte history: shift current into previous on each load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else if (w_loaddata) begin
      r_prev <= r_cur;
      r_cur  <= inputdata;
    end
  end

  // Digit 3 is prev high nibble down to digit 0 = cur low nibble.
  assign w_nib = {r_prev, r_cur};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_to_7seg u_dec (
      .i_nib (w_nib[g]),
      .o_seg (w_seg[g])
    );
  end

  assign disp3 = w_seg[3];
  assign disp2 = w_seg[2];
  assign disp1 = w_seg[1];
  assign disp0 = w_seg[0];
endmodule

// File: tb/tb_byte_entry_display.sv
// Bench: table vectors, directed corner sequences and random stimulus, all
// compared against a sample-history model of the enter/load rules.
module tb_byte_entry_display;
  logic       clk = 1'b0;
  logic       reset, enter;
  logic [7:0] inputdata;
  logic [6:0] disp3, disp2, disp1, disp0;

  always #5 clk = ~clk;

  byte_entry_display dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .inputdata (inputdata),
    .disp3     (disp3),
    .disp2     (disp2),
    .disp1     (disp1),
    .disp0     (disp0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [27:0] dexp(input logic [7:0] p, input logic [7:0] c);
    return {segtab[p[7:4]], segtab[p[3:0]], segtab[c[7:4]], segtab[c[3:0]]};
  endfunction

  // Reference model: smp[k] = enter as sampled k edges ago (zeroed by reset).
  // A load happens at edge n when sample n-3 is high and sample n-4 is low.
  logic [4:0] smp;
  logic [7:0] m_cur, m_prev;
  logic       m_ld;

  // Observed load pulses and their widest run.
  int ld_cnt = 0, run = 0, max_run = 0;
  always @(posedge clk) begin
    if (dut.w_loaddata === 1'b1) begin
      ld_cnt <= ld_cnt + 1;
      run    <= run + 1;
    end else begin
      run <= 0;
    end
    if (run > max_run) max_run <= run;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [7:0] d);
    reset = rst; enter = en; inputdata = d;
    @(posedge clk);
    if (rst) begin
      smp = '0; m_cur = '0; m_prev = '0;
    end else begin
      smp = {smp[3:0], en};
      if (smp[3] && !smp[4]) begin
        m_prev = m_cur;
        m_cur  = d;
      end
    end
    m_ld = smp[2] && !smp[3];
    @(negedge clk);
    chk("model_disp", {4'h0, disp3, disp2, disp1, disp0}, {4'h0, dexp(m_prev, m_cur)});
    chk("model_loaddata", {31'd0, dut.w_loaddata}, {31'd0, m_ld});
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] prev;
    logic [7:0] cur;
  } vec_t;
  vec_t vt[$];

  int base;
  logic en_r;

  initial begin
    reset = 1'b1; enter = 1'b0; inputdata = 8'h00;
    smp = '0; m_cur = '0; m_prev = '0; m_ld = 1'b0;

    // Reset, single A5 load (enter held 10 cycles), then 3C and F1.
    vt.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 1'b1, 8'hA5, 8'h00, 8'h00});
    for (int i = 0; i < 7; i++) vt.push_back('{1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5});
    vt.push_back('{1'b0, 1'b0, 8'hA5, 8'h00, 8'hA5});
    vt.push_back('{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5});
    vt.push_back('{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h3C});
    vt.push_back('{1'b0, 1'b0, 8'hF1, 8'hA5, 8'h3C});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 1'b1, 8'hF1, 8'hA5, 8'h3C});
    vt.push_back('{1'b0, 1'b1, 8'hF1, 8'h3C, 8'hF1});
    vt.push_back('{1'b0, 1'b0, 8'hF1, 8'h3C, 8'hF1});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].en, vt[i].d);
      chk($sformatf("vec%0d", i), {4'h0, disp3, disp2, disp1, disp0},
          {4'h0, dexp(vt[i].prev, vt[i].cur)});
    end
    chk("vec_load_count", ld_cnt, 3);

    // Held 50 cycles, low 1 cycle, high again: two loads only.
    base = ld_cnt;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, (i < 5) ? 8'h11 : 8'h22);
    step(1'b0, 1'b0, 8'h22);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h33);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h33);
    chk("glitch_load_count", ld_cnt - base, 2);
    chk("glitch_disp", {4'h0, disp3, disp2, disp1, disp0}, {4'h0, dexp(8'h11, 8'h33)});
    chk("glitch_ld_width", max_run, 1);

    // Reset in the LOAD cycle aborts the load of 77.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h77);
    chk("abort_in_load", {31'd0, dut.w_loaddata}, 32'd1);
    step(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h77);
    chk("abort_disp", {4'h0, disp3, disp2, disp1, disp0}, {4'h0, dexp(8'h00, 8'h00)});

    // Enter held through reset: one load three cycles after release.
    base = ld_cnt;
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("held_rst_early", ld_cnt - base, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    chk("held_rst_load_count", ld_cnt - base, 1);
    chk("held_rst_disp", {4'h0, disp3, disp2, disp1, disp0}, {4'h0, dexp(8'h00, 8'h00)});
    step(1'b0, 1'b0, 8'h00);

    // Random enter runs, data and occasional resets.
    en_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) en_r = ~en_r;
      step(($urandom_range(0, 59) == 0), en_r, 8'($urandom));
    end
    chk("final_ld_width", max_run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
